// File: rtl/pipe_scroller_pkg.sv
// Shared VGA timing constants, derived widths and state encodings for the
// pipe scroller game-state stage.
package pipe_scroller_pkg;

    localparam int unsigned WIDTH  = 640;
    localparam int unsigned H_TOT  = 800;
    localparam int unsigned HEIGHT = 480;
    localparam int unsigned V_TOT  = 525;
    localparam int unsigned P_NUM  = 4;

    localparam int unsigned HW = $clog2(H_TOT);
    localparam int unsigned VW = $clog2(V_TOT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STOP = 2'b10
    } state_t;

endpackage

// File: rtl/pipe_scroller_if.sv
// Control inputs and renderer-facing outputs of the pipe scroller.
interface pipe_scroller_if;
    import pipe_scroller_pkg::*;

    logic                  iFrameTick;
    logic                  iStart;
    logic                  iCollision;
    logic [HW-1:0]         oPipePos;
    logic [P_NUM*VW-1:0]   oWindowsPos;
    logic [7:0]            oScore;
    logic [1:0]            oState;

    modport master (
        output iFrameTick, iStart, iCollision,
        input  oPipePos, oWindowsPos, oScore, oState
    );

    modport slave (
        input  iFrameTick, iStart, iCollision,
        output oPipePos, oWindowsPos, oScore, oState
    );

endinterface

// File: rtl/pipe_scroller_window_lfsr.sv
// Free-running 16-bit Galois LFSR folded into a window height range.
module window_lfsr
    import pipe_scroller_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned WIN_MIN   = 80,
    parameter int unsigned WIN_RANGE = 221
) (
    input  logic          clk,
    input  logic          rst,
    output logic [VW-1:0] window
);

    logic [15:0] lfsr;
    logic [8:0]  fold;

    // Right-shifting Galois LFSR, x^16+x^14+x^13+x^11+1, runs every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    // Low byte folded once into 0..WIN_RANGE-1, then offset by WIN_MIN.
    always_comb begin
        fold = {1'b0, lfsr[7:0]};
        if (fold >= 9'(WIN_RANGE)) begin
            fold = fold - 9'(WIN_RANGE);
        end
        window = VW'(WIN_MIN) + VW'(fold);
    end

endmodule

// File: rtl/pipe_scroller.sv
// Per-frame pipe position, gap windows and BCD score with run/stop control.
module pipe_scroller
    import pipe_scroller_pkg::*;
#(
    parameter int unsigned PIPE_W       = 64,
    parameter int unsigned PIPE_SPACING = 160,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned BIRD_X       = 200,
    parameter int unsigned INIT_X       = 640,
    parameter int unsigned WIN_INIT     = 200,
    parameter int unsigned WIN_MIN      = 80,
    parameter int unsigned WIN_RANGE    = 221,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic             iClk,
    input  logic             iRst,
    pipe_scroller_if.slave   bus
);

    state_t        state;
    logic [HW-1:0] pipePos;
    logic [VW-1:0] win [P_NUM];
    logic [7:0]    score;
    logic [VW-1:0] newWin;

    logic [HW:0]   posExt;
    logic [HW:0]   movedPos;
    logic [HW:0]   recycledPos;
    logic          normalMove;
    logic          crossing;
    logic [7:0]    scoreInc;

    window_lfsr #(
        .SEED      (LFSR_SEED),
        .WIN_MIN   (WIN_MIN),
        .WIN_RANGE (WIN_RANGE)
    ) uLfsr (
        .clk    (iClk),
        .rst    (iRst),
        .window (newWin)
    );

    // Move arithmetic at HW+1 bits so sums never wrap.
    always_comb begin
        posExt      = {1'b0, pipePos};
        normalMove  = posExt >= (HW+1)'(SPEED);
        movedPos    = posExt - (HW+1)'(SPEED);
        recycledPos = posExt + (HW+1)'(PIPE_SPACING) - (HW+1)'(SPEED);
        crossing    = ((posExt + (HW+1)'(PIPE_W)) >= (HW+1)'(BIRD_X)) &&
                      ((movedPos + (HW+1)'(PIPE_W)) < (HW+1)'(BIRD_X));
    end

    // Saturating two-digit BCD increment.
    always_comb begin
        scoreInc = score;
        if (score != 8'h99) begin
            if (score[3:0] == 4'd9) begin
                scoreInc = {score[7:4] + 4'd1, 4'd0};
            end else begin
                scoreInc = {score[7:4], score[3:0] + 4'd1};
            end
        end
    end

    // Run/stop controller and all registered game state.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= ST_IDLE;
            pipePos <= HW'(INIT_X);
            score   <= 8'h00;
            for (int unsigned k = 0; k < P_NUM; k++) win[k] <= VW'(WIN_INIT);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.iStart) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.iCollision) begin
                        state <= ST_STOP;
                    end else if (bus.iFrameTick) begin
                        if (normalMove) begin
                            pipePos <= movedPos[HW-1:0];
                            if (crossing) score <= scoreInc;
                        end else begin
                            pipePos <= recycledPos[HW-1:0];
                            for (int unsigned k = 0; k < P_NUM - 1; k++) win[k] <= win[k+1];
                            win[P_NUM-1] <= newWin;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.iStart) begin
                        state   <= ST_IDLE;
                        pipePos <= HW'(INIT_X);
                        score   <= 8'h00;
                        for (int unsigned k = 0; k < P_NUM; k++) win[k] <= VW'(WIN_INIT);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Window slots packed for the renderer.
    always_comb begin
        bus.oWindowsPos = '0;
        for (int unsigned k = 0; k < P_NUM; k++) bus.oWindowsPos[k*VW +: VW] = win[k];
    end

    assign bus.oPipePos = pipePos;
    assign bus.oScore   = score;
    assign bus.oState   = state;

endmodule

// File: doc/pipe_scroller.md
Name: pipe_scroller

Overview:
- Game-state stage directly upstream of the frame renderer.
- Owns the horizontal pipe position, the per-pipe gap (window) heights and the two-digit BCD score.
- Outputs feed the renderer's pipe-position, windows-position and score inputs.
- Updates once per video frame on a frame tick, so the displayed frame never changes mid-scan.
- Holds a three-state run/stop controller driven by start and collision inputs.

Parameters:
- WIDTH, 640, visible width in pixels
- H_TOT, 800, total horizontal count; position width HW = $clog2(H_TOT) = 10
- V_TOT, 525, total vertical count; window width VW = $clog2(V_TOT) = 10
- P_NUM, 4, number of pipes/windows tracked
- PIPE_W, 64, pipe width in pixels
- PIPE_SPACING, 160, left-edge distance between consecutive pipes
- SPEED, 2, pixels moved per frame tick
- BIRD_X, 200, bird x column used for scoring; constraint BIRD_X > PIPE_W + SPEED
- INIT_X, 640, leftmost pipe x after reset/re-init
- WIN_INIT, 200, window value for all slots after reset/re-init
- WIN_MIN, 80, lowest generated window value
- WIN_RANGE, 221, generated values span WIN_MIN .. WIN_MIN+WIN_RANGE-1; must be ≤256
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
- iClk  in  1  system clock (pixel clock domain)
- iRst  in  1  synchronous, active-high reset
- iFrameTick  in  1  one-cycle pulse per frame, issued at start of vertical blank
- iStart  in  1  level or pulse; starts the game or acknowledges game over
- iCollision  in  1  bird hit pipe or ground
- oPipePos  out  HW  left edge x of pipe 0 (leftmost)
- oWindowsPos  out  P_NUM*VW  window of pipe k at bits [k*VW +: VW]
- oScore  out  8  BCD score; [7:4] tens digit, [3:0] units digit
- oState  out  2  00 IDLE, 01 RUN, 10 STOP

Behaviour:
- Reset (iRst=1 at a clock edge):
  - oPipePos=INIT_X, every window slot=WIN_INIT, oScore=8'h00, oState=IDLE, LFSR=LFSR_SEED.
  - Reset overrides all other inputs, including a reset asserted mid-run.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, shifts right every clock in every state.
- Window generation: c = lfsr[7:0]; if c ≥ WIN_RANGE then c = c - WIN_RANGE; new window = WIN_MIN + c.
- State transitions:
  - IDLE: no movement. iStart → RUN.
  - RUN: when iFrameTick=1, perform a move (below). iCollision=1 → STOP, with no move that cycle even if iFrameTick=1.
  - STOP: all outputs frozen. iStart → IDLE and, in the same edge, re-init oPipePos, all windows and oScore to their reset values. The LFSR is not reseeded.
- Move (RUN and iFrameTick):
  - Normal: if oPipePos ≥ SPEED, then oPipePos -= SPEED.
  - Recycle: if oPipePos < SPEED, then oPipePos = oPipePos + PIPE_SPACING - SPEED. Window slot k takes slot k+1 for k < P_NUM-1; slot P_NUM-1 takes a freshly generated window.
  - Score: on a normal move, if old oPipePos + PIPE_W ≥ BIRD_X and new oPipePos + PIPE_W < BIRD_X, increment the score once in BCD.
    - Units 9 → 0 with tens+1.
    - Saturate at 8'h99.
  - Recycle moves never score.
- Latency: all outputs are registered and change one cycle after the iFrameTick edge; they are stable for the rest of the frame.
- Arithmetic: sums are computed at HW+1 bits to avoid wrap; oPipePos never exceeds INIT_X.
- iStart in RUN is ignored. iStart asserted together with iCollision in RUN gives STOP.

Decomposition:
- Shared package: VGA timing constants (WIDTH, H_TOT, HEIGHT, V_TOT), state encodings (ST_IDLE, ST_RUN, ST_STOP), derived widths HW/VW.
- One sub-module, window_lfsr: the LFSR plus range fold. Ports: clock, reset, seed parameter, VW-bit window output.
- BCD increment stays inline.

Test Plan:
- Reset, then idle 5 ticks → oPipePos=640, every window=200, oScore=8'h00, oState=00, no change.
- iStart pulse, then 10 ticks → oPipePos=620 exactly one cycle after the 10th tick; oState=01.
- Run 253 ticks from start → score 8'h00 through tick 252 (oPipePos=136); oScore becomes 8'h01 at tick 253 (oPipePos=134).
- Run to oPipePos=0 (tick 320), one more tick → oPipePos=158, slot0 = old slot1, slot3 = a value in range 80..300, oScore unchanged.
- Pipe-pass scoring with small PIPE_SPACING: drive score past 8'h09 → 8'h10; past 8'h99 → stays 8'h99.
- iCollision coincident with iFrameTick at oPipePos=500 → oPipePos stays 500, oState=10; further ticks have no effect. iStart → oState=00, oPipePos=640, oScore=8'h00. Assert iRst mid-RUN → all reset values on the next edge.
